// File: rtl/pulse_gen_if.sv
// pulse_gen_if
// Groups the controller-facing signals of the step pulse generator.
//   master : the motion controller (drives the request, observes status)
//   slave  : pulse_gen itself
// Signals:
//   Enable     - start request from the controller
//   PulseNum   - number of step pulses to emit (10 bits)
//   Motor      - target motor index 0..5
//   DRs        - direction bits per motor (1 reverse, 0 forward)
//   Busy       - job in progress
//   STPs       - step pulse per motor
//   DIRs       - registered direction outputs to the drivers
//   Done       - one-cycle completion strobe
//   PulseCount - pulses completed in the current or last job
interface pulse_gen_if;
    logic       Enable;
    logic [9:0] PulseNum;
    logic [2:0] Motor;
    logic [5:0] DRs;
    logic       Busy;
    logic [5:0] STPs;
    logic [5:0] DIRs;
    logic       Done;
    logic [9:0] PulseCount;

    modport master (
        output Enable, PulseNum, Motor, DRs,
        input  Busy, STPs, DIRs, Done, PulseCount
    );

    modport slave (
        input  Enable, PulseNum, Motor, DRs,
        output Busy, STPs, DIRs, Done, PulseCount
    );
endinterface

// File: rtl/pulse_gen.sv
// pulse_gen
// Emits a burst of step pulses on one of six motor step lines. A job is
// accepted from IDLE when Enable is high with a non-zero pulse count and a
// valid motor index; direction bits are loaded first, held for DIR_SETUP
// cycles, then PulseNum pulses of HALF_PERIOD high / HALF_PERIOD low follow,
// ending with a one-cycle Done strobe.
// Parameters:
//   HALF_PERIOD - cycles STP is high and also low per pulse (1..65535)
//   DIR_SETUP   - cycles DIR is stable before the first STP rise (1..65535)
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - pulse_gen_if.slave (request inputs, registered status outputs)
module pulse_gen #(
    parameter int HALF_PERIOD = 500,
    parameter int DIR_SETUP   = 10
) (
    input logic        clk,
    input logic        rst,
    pulse_gen_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] HIGH  = 3'd2;
    localparam logic [2:0] LOW   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    // Timers count down to zero, so a phase of N cycles loads N-1.
    // 16 bits covers the full parameter range without wrapping.
    localparam logic [15:0] SETUP_LOAD = 16'(DIR_SETUP - 1);
    localparam logic [15:0] HALF_LOAD  = 16'(HALF_PERIOD - 1);

    logic [2:0]  state;
    logic [15:0] timer;
    logic [9:0]  num_q;
    logic [2:0]  motor_q;
    logic [5:0]  step_mask;
    logic [9:0]  count_next;

    // motor_q is only ever loaded with 0..5, so the mask is always one-hot.
    assign step_mask  = 6'b000001 << motor_q;
    assign count_next = bus.PulseCount + 10'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= '0;
            num_q          <= '0;
            motor_q        <= '0;
            bus.Busy       <= 1'b0;
            bus.STPs       <= '0;
            bus.DIRs       <= '0;
            bus.Done       <= 1'b0;
            bus.PulseCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Invalid requests fall through silently.
                    if (bus.Enable && (bus.PulseNum != 10'd0) && (bus.Motor <= 3'd5)) begin
                        num_q          <= bus.PulseNum;
                        motor_q        <= bus.Motor;
                        bus.DIRs       <= bus.DRs;
                        bus.PulseCount <= '0;
                        bus.Busy       <= 1'b1;
                        timer          <= SETUP_LOAD;
                        state          <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer == 16'd0) begin
                        bus.STPs <= step_mask;
                        timer    <= HALF_LOAD;
                        state    <= HIGH;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                HIGH: begin
                    if (timer == 16'd0) begin
                        bus.STPs <= '0;
                        timer    <= HALF_LOAD;
                        state    <= LOW;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                LOW: begin
                    // The pulse completes as LOW ends; the outputs are
                    // registered so they change together with the state.
                    if (timer == 16'd0) begin
                        bus.PulseCount <= count_next;
                        if (count_next == num_q) begin
                            bus.Done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            bus.STPs <= step_mask;
                            timer    <= HALF_LOAD;
                            state    <= HIGH;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                DONE: begin
                    bus.Done <= 1'b0;
                    bus.Busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.Done <= 1'b0;
                    bus.Busy <= 1'b0;
                    bus.STPs <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen
// Self-checking bench for pulse_gen with HALF_PERIOD=2, DIR_SETUP=1.
// Accepted jobs are queued when driven; each Done strobe pops one entry and
// compares count, motor pulses, directions and Busy length.
module tb_pulse_gen;

    localparam int HP = 2;
    localparam int DS = 1;

    typedef struct {
        logic [9:0] num;
        logic [2:0] motor;
        logic [5:0] dirs;
    } job_t;

    logic clk;
    logic rst;

    pulse_gen_if bus ();

    pulse_gen #(
        .HALF_PERIOD(HP),
        .DIR_SETUP  (DS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    job_t sb[$];
    job_t exp_job;

    int assertions  = 0;
    int failures    = 0;
    int done_count  = 0;
    int total_edges = 0;
    int busy_len    = 0;
    int idle_len    = 0;
    int last_gap    = 0;
    int hi_run      = 0;
    int lo_run      = 0;
    int job_edges   = 0;
    int edges[6];
    int other_edges;
    logic       prev_busy = 1'b0;
    logic       prev_done = 1'b0;
    logic [5:0] prev_stp  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives a request and queues one expected result per job it should start.
    task automatic applyStimulus(input logic en, input logic [9:0] num, input logic [2:0] motor,
                                 input logic [5:0] drs, input int jobs);
        job_t j;
        bus.Enable   = en;
        bus.PulseNum = num;
        bus.Motor    = motor;
        bus.DRs      = drs;
        j.num   = num;
        j.motor = motor;
        j.dirs  = drs;
        for (int k = 0; k < jobs; k++) sb.push_back(j);
    endtask

    task automatic waitDone(input int budget, input string tag);
        int start;
        start = done_count;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (done_count != start) return;
        end
        checkOutput(tag, 0, 1);
    endtask

    // Monitor: measures pulse widths, Busy span and gaps, and retires jobs on Done.
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            prev_done = 1'b0;
            prev_stp  = '0;
            hi_run    = 0;
            lo_run    = 0;
        end else begin
            if (prev_done) checkOutput("idle after done", {30'd0, bus.Busy, bus.Done}, 32'd0);
            if (bus.Busy && !prev_busy) begin
                last_gap  = idle_len;
                idle_len  = 0;
                busy_len  = 0;
                job_edges = 0;
                for (int i = 0; i < 6; i++) edges[i] = 0;
            end
            if (bus.Busy) busy_len++;
            else idle_len++;
            for (int i = 0; i < 6; i++) begin
                if (bus.STPs[i] && !prev_stp[i]) begin
                    edges[i]++;
                    total_edges++;
                end
            end
            if (bus.STPs != 6'd0) begin
                if (prev_stp == 6'd0) begin
                    if (job_edges > 0) checkOutput("stp low width", lo_run, HP);
                    job_edges++;
                    hi_run = 0;
                end
                hi_run++;
            end else begin
                if (prev_stp != 6'd0) begin
                    checkOutput("stp high width", hi_run, HP);
                    lo_run = 0;
                end
                lo_run++;
            end
            if (bus.Done) begin
                done_count++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected done", 1, 0);
                end else begin
                    exp_job = sb.pop_front();
                    other_edges = 0;
                    for (int i = 0; i < 6; i++)
                        if (i != int'(exp_job.motor)) other_edges += edges[i];
                    checkOutput("done pulse count", bus.PulseCount, exp_job.num);
                    checkOutput("motor edges", edges[exp_job.motor], exp_job.num);
                    checkOutput("other motor edges", other_edges, 0);
                    checkOutput("dirs at done", bus.DIRs, exp_job.dirs);
                    checkOutput("busy at done", bus.Busy, 1);
                    checkOutput("busy span", busy_len, DS + 2 * HP * int'(exp_job.num) + 1);
                end
            end
            prev_busy = bus.Busy;
            prev_done = bus.Done;
            prev_stp  = bus.STPs;
        end
    end

    initial begin
        int waited;
        int edges_before;
        int dones_before;

        rst = 1'b1;
        applyStimulus(1'b0, 10'd0, 3'd0, 6'd0, 0);
        repeat (3) @(negedge clk);
        checkOutput("reset busy", bus.Busy, 0);
        checkOutput("reset stps", bus.STPs, 0);
        checkOutput("reset dirs", bus.DIRs, 0);
        checkOutput("reset done", bus.Done, 0);
        checkOutput("reset count", bus.PulseCount, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic job on motor 2.
        applyStimulus(1'b1, 10'd3, 3'd2, 6'b000100, 1);
        @(negedge clk);
        applyStimulus(1'b0, 10'd3, 3'd2, 6'b000100, 0);
        checkOutput("basic dirs", bus.DIRs, 6'b000100);
        checkOutput("basic busy", bus.Busy, 1);
        waitDone(100, "basic timeout");
        repeat (3) @(negedge clk);

        // Rejected requests.
        dones_before = done_count;
        edges_before = total_edges;
        applyStimulus(1'b1, 10'd0, 3'd1, 6'b111111, 0);
        repeat (4) @(negedge clk);
        checkOutput("reject zero busy", bus.Busy, 0);
        checkOutput("reject zero stps", bus.STPs, 0);
        applyStimulus(1'b1, 10'd4, 3'd7, 6'b111111, 0);
        repeat (4) @(negedge clk);
        checkOutput("reject motor busy", bus.Busy, 0);
        checkOutput("reject motor dirs", bus.DIRs, 6'b000100);
        applyStimulus(1'b0, 10'd0, 3'd0, 6'd0, 0);
        checkOutput("reject no done", done_count, dones_before);
        checkOutput("reject no edges", total_edges, edges_before);

        // Inputs changed while busy must not affect the job.
        applyStimulus(1'b1, 10'd2, 3'd3, 6'b101010, 1);
        repeat (4) @(negedge clk);
        applyStimulus(1'b1, 10'd9, 3'd0, 6'd0, 0);
        repeat (2) @(negedge clk);
        checkOutput("busy dirs held", bus.DIRs, 6'b101010);
        applyStimulus(1'b0, 10'd9, 3'd0, 6'd0, 0);
        waitDone(100, "ignore timeout");
        repeat (3) @(negedge clk);

        // Reset in the middle of a pulse.
        applyStimulus(1'b1, 10'd3, 3'd1, 6'b000010, 1);
        @(negedge clk);
        applyStimulus(1'b0, 10'd3, 3'd1, 6'b000010, 0);
        waited = 0;
        while (!bus.STPs[1] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("stp1 seen", bus.STPs[1], 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset stps", bus.STPs, 0);
        checkOutput("midreset dirs", bus.DIRs, 0);
        checkOutput("midreset busy", bus.Busy, 0);
        checkOutput("midreset done", bus.Done, 0);
        checkOutput("midreset count", bus.PulseCount, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        edges_before = total_edges;
        dones_before = done_count;
        repeat (30) @(negedge clk);
        checkOutput("post reset edges", total_edges, edges_before);
        checkOutput("post reset busy", bus.Busy, 0);
        checkOutput("post reset done", done_count, dones_before);

        // Back-to-back jobs with Enable held high.
        applyStimulus(1'b1, 10'd1, 3'd4, 6'b010000, 3);
        waitDone(50, "b2b timeout 1");
        waitDone(50, "b2b timeout 2");
        checkOutput("b2b gap", last_gap, 1);
        waitDone(50, "b2b timeout 3");
        applyStimulus(1'b0, 10'd1, 3'd4, 6'b010000, 0);
        checkOutput("b2b gap 2", last_gap, 1);
        repeat (10) @(negedge clk);
        checkOutput("b2b stopped", bus.Busy, 0);

        // Full 1023-pulse job on motor 5.
        applyStimulus(1'b1, 10'd1023, 3'd5, 6'b100001, 1);
        @(negedge clk);
        applyStimulus(1'b0, 10'd0, 3'd0, 6'd0, 0);
        waitDone(5000, "full timeout");
        repeat (3) @(negedge clk);

        checkOutput("scoreboard empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- HALF_PERIOD, 500, clk cycles STP is high and also low per pulse (>=1).
- DIR_SETUP, 10, clk cycles DIR is held stable before the first STP rising edge (>=1).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, reset, asynchronous, active-high.
- Enable, input, 1, start request from the controller.
- PulseNum, input, 10, number of step pulses to emit.
- Motor, input, 3, target motor index 0..5.
- DRs, input, 6, direction bits per motor (1 reverse, 0 forward).
- Busy, output, 1, job in progress; the controller holds off while it is high.
- STPs, output, 6, step pulse per motor.
- DIRs, output, 6, registered direction outputs to the drivers.
- Done, output, 1, one-cycle completion strobe.
- PulseCount, output, 10, pulses completed in the current or last job.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The FSM SHALL have states IDLE, SETUP, HIGH, LOW and DONE.
REQ-005 In IDLE with Busy=0, Enable=1 and PulseNum!=0 and Motor<=5 sampled at edge N, the block SHALL do all of the following:
- latch PulseNum, Motor and DRs;
- load DIRs with DRs;
- clear PulseCount;
- assert Busy from N+1;
- enter SETUP.
REQ-006 In IDLE, Enable=1 with PulseNum==0 or Motor>5 SHALL be ignored: no Busy, no Done, no output change.
REQ-007 SETUP SHALL last exactly DIR_SETUP cycles, then the FSM SHALL enter HIGH.
REQ-008 In HIGH, STPs[latched Motor] SHALL be 1 and all other STPs bits 0, for exactly HALF_PERIOD cycles, then the FSM SHALL enter LOW.
REQ-009 In LOW, all STPs SHALL be 0 for exactly HALF_PERIOD cycles. On leaving LOW, PulseCount SHALL increment.
REQ-010 On leaving LOW, the FSM SHALL enter DONE if PulseCount+1 equals the latched PulseNum, else HIGH.
REQ-011 DONE SHALL last one cycle with Done=1 and Busy=1. The next cycle SHALL be IDLE with Busy=0 and Done=0.
REQ-012 Busy SHALL span exactly DIR_SETUP + 2*HALF_PERIOD*PulseNum + 1 cycles.
REQ-013 While Busy=1, changes on Enable, PulseNum, Motor and DRs SHALL have no effect on the job in progress.
REQ-014 DIRs SHALL change only on job acceptance (REQ-005) and SHALL otherwise hold their value between jobs. Bits of unselected motors SHALL also take the DRs value at acceptance.
REQ-015 Enable held high continuously SHALL start a new job at the first IDLE cycle after DONE. There SHALL be no Busy-low gap longer than one cycle.
REQ-016 Timers SHALL be sized for HALF_PERIOD and DIR_SETUP up to 2^16-1 and SHALL not wrap. PulseNum=1023 SHALL produce exactly 1023 pulses.

Reset
REQ-017 Asserting rst at any time, including mid-pulse, SHALL immediately force:
- the FSM to IDLE;
- STPs=0, DIRs=0, Busy=0, Done=0, PulseCount=0.
The aborted job SHALL be discarded. No pulse SHALL resume after rst is released.

Verification (HALF_PERIOD=2, DIR_SETUP=1)
REQ-018 Basic job: Enable=1, PulseNum=3, Motor=2, DRs=6'b000100.
- DIRs=6'b000100 and Busy=1 from the next edge.
- STPs[2] produces 3 pulses of 2 cycles high and 2 cycles low.
- Busy lasts 14 cycles, then Done pulses once and PulseCount=3.
REQ-019 Rejected requests: Enable=1 with PulseNum=0, then with Motor=7 -> Busy stays 0, STPs=0, Done never asserts.
REQ-020 Inputs ignored while busy: mid-job, change PulseNum to 9, Motor to 0 and DRs to 0 -> the running job still emits its original count on the original motor, and DIRs are unchanged.
REQ-021 Reset mid-pulse: assert rst while STPs[1]=1 -> all outputs are 0 the same cycle; after release, no pulses until a new Enable.
REQ-022 Back-to-back jobs: hold Enable=1 with PulseNum=1 -> jobs repeat with a one-cycle Busy=0 gap. Each job gives exactly one pulse and one Done.
REQ-023 Full count: PulseNum=1023, Motor=5 -> exactly 1023 rising edges on STPs[5] and PulseCount=1023 at Done.
